// File: rtl/ping_responder.sv
// Ping responder: qualifies a burst on the synchronized detector stream, waits for it to end,
// then fires a one-cycle tx strobe after a fixed turnaround and blanks for a holdoff period.
module ping_responder #(
  parameter int unsigned DET_WIN    = 64,
  parameter int unsigned DET_THR    = 48,
  parameter int unsigned QUIET_LEN  = 32,
  parameter int unsigned MAX_PING   = 48000,
  parameter int unsigned TURNAROUND = 4800,
  parameter int unsigned HOLDOFF    = 60000,
  parameter int unsigned CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sig,
  input  logic       tx_en,
  output logic       tx_stb,
  output logic       det_stb,
  output logic       busy,
  output logic [7:0] reply_count,
  output logic [7:0] reject_count
);

  localparam logic [CW-1:0] WIN_C  = CW'(DET_WIN);
  localparam logic [CW-1:0] THR_C  = CW'(DET_THR);
  localparam logic [CW-1:0] QL_C   = CW'(QUIET_LEN);
  localparam logic [CW-1:0] MP_C   = CW'(MAX_PING);
  localparam logic [CW-1:0] TA_C   = CW'(TURNAROUND);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLDOFF - 1);

  typedef enum logic [2:0] {IDLE, DETECT, QUIET, TURN, HOLD} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] win_q, win_d, high_q, high_d, low_q, low_d, tmr_q, tmr_d;
  logic          tx_stb_q, tx_stb_d, det_stb_q, det_stb_d, busy_q;
  logic [7:0]    reply_q, reply_d, reject_q, reject_d;
  logic          sig_s;
  logic [CW-1:0] win_nx, high_nx, low_nx, tmr_nx;

  assign sig_s   = sync_q[1];
  assign win_nx  = win_q + CW'(1);
  assign high_nx = high_q + CW'(sig_s);
  assign low_nx  = sig_s ? '0 : low_q + CW'(1);
  assign tmr_nx  = tmr_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    high_d    = high_q;
    low_d     = low_q;
    tmr_d     = tmr_q;
    tx_stb_d  = 1'b0;
    det_stb_d = 1'b0;
    reply_d   = reply_q;
    reject_d  = reject_q;
    if (!enable) begin
      state_d = IDLE;
      win_d   = '0;
      high_d  = '0;
      low_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_en && sig_s) begin
            state_d = DETECT;
            win_d   = CW'(1);
            high_d  = CW'(1);
          end
        end
        DETECT: begin
          win_d  = win_nx;
          high_d = high_nx;
          if (win_nx == WIN_C) begin
            if (high_nx >= THR_C) begin
              state_d   = QUIET;
              det_stb_d = 1'b1;
              low_d     = '0;
              tmr_d     = '0;
            end else begin
              state_d  = IDLE;
              reject_d = reject_q + 8'd1;
            end
          end
        end
        // tmr_q is the ping duration here, then reused as turnaround and holdoff timer
        QUIET: begin
          low_d = low_nx;
          tmr_d = tmr_nx;
          if (low_nx == QL_C) begin
            state_d = TURN;
            tmr_d   = '0;
          end else if (tmr_nx == MP_C) begin
            state_d  = IDLE;
            reject_d = reject_q + 8'd1;
          end
        end
        TURN: begin
          tmr_d = tmr_nx;
          if (tmr_nx == TA_C) begin
            state_d  = HOLD;
            tmr_d    = '0;
            tx_stb_d = 1'b1;
            reply_d  = reply_q + 8'd1;
          end
        end
        HOLD: begin
          if (tmr_q == HOLD_C) begin
            if (!tx_en) state_d = IDLE;
          end else begin
            tmr_d = tmr_nx;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      win_q     <= '0;
      high_q    <= '0;
      low_q     <= '0;
      tmr_q     <= '0;
      tx_stb_q  <= 1'b0;
      det_stb_q <= 1'b0;
      busy_q    <= 1'b0;
      reply_q   <= '0;
      reject_q  <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], sig};
      win_q     <= win_d;
      high_q    <= high_d;
      low_q     <= low_d;
      tmr_q     <= tmr_d;
      tx_stb_q  <= tx_stb_d;
      det_stb_q <= det_stb_d;
      busy_q    <= (state_d != IDLE);
      reply_q   <= reply_d;
      reject_q  <= reject_d;
    end
  end

  assign tx_stb       = tx_stb_q;
  assign det_stb      = det_stb_q;
  assign busy         = busy_q;
  assign reply_count  = reply_q;
  assign reject_count = reject_q;

endmodule

// File: tb/tb_ping_responder.sv
// Bench for ping_responder: directed and random input streams, an episode-level reference model
// filling an event scoreboard and a per-cycle busy expectation, and a monitor that checks both.
module tb_ping_responder;

  localparam int DW = 8, DT = 6, QL = 4, MP = 100, TA = 10, HO = 20;
  localparam int N  = 40000;
  localparam int K_DET = 0, K_TX = 1, K_REJ = 2;

  logic       clk = 1'b0;
  logic       rst, enable, sig, tx_en;
  logic       tx_stb, det_stb, busy;
  logic [7:0] reply_count, reject_count;

  ping_responder #(
    .DET_WIN(DW), .DET_THR(DT), .QUIET_LEN(QL), .MAX_PING(MP),
    .TURNAROUND(TA), .HOLDOFF(HO), .CW(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sig(sig), .tx_en(tx_en),
    .tx_stb(tx_stb), .det_stb(det_stb), .busy(busy),
    .reply_count(reply_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         at;
    logic [7:0] rep;
    logic [7:0] rej;
  } ev_t;

  // Per-interval stimulus; interval c is the time between posedge c and posedge c+1.
  bit   sigd [N];
  bit   en   [N];
  bit   txe  [N];
  bit   rs   [N];
  bit   busy_exp [N];
  ev_t  exq[$];
  int   p = 0;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   tx_seen = 0, tx_at_start = 0, m_tx = 0;
  int   wrap_start = 0, wrap_end = 0;
  int   busy_prints = 0;
  logic [7:0] m_reply = '0, m_reject = '0, prev_rej = '0;

  task automatic app(input bit s, input bit e, input bit t, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      if (p < N) begin
        sigd[p] = s; en[p] = e; txe[p] = t; rs[p] = r;
      end
      p++;
    end
  endtask

  task automatic clean_ping();
    app(1'b1, 1'b1, 1'b0, 1'b0, 40);
    app(1'b0, 1'b1, 1'b0, 1'b0, 45);
  endtask

  // ---------------- reference model ----------------
  function automatic bit ss(int c);
    if (c < 2) return 1'b0;
    return sigd[c-2] & ~rs[c-1] & ~rs[c-2];
  endfunction

  function automatic bit intr(int c);
    return rs[c] || !en[c];
  endfunction

  function automatic void push(int kind, int at);
    ev_t e;
    e.kind = kind; e.at = at; e.rep = m_reply; e.rej = m_reject;
    exq.push_back(e);
  endfunction

  function automatic void do_abort(int c);
    if (rs[c]) begin
      m_reply = '0;
      if (m_reject != 8'd0) begin
        m_reject = '0;
        push(K_REJ, c + 1);
      end
    end
  endfunction

  // Walks one episode starting at an idle interval; returns the next idle interval.
  function automatic int episode(int c_in);
    int c, c0, sum, low, d, q, n;
    c = c_in;
    if (rs[c]) begin do_abort(c); return c + 1; end
    if (!en[c] || txe[c] || !ss(c)) return c + 1;
    c0 = c; sum = 1;
    for (int k = 1; k < DW; k++) begin
      c = c0 + k;
      if (c >= N) return N;
      busy_exp[c] = 1'b1;
      if (intr(c)) begin do_abort(c); return c + 1; end
      sum += int'(ss(c));
    end
    if (sum < DT) begin
      m_reject = m_reject + 8'd1;
      push(K_REJ, c + 1);
      return c + 1;
    end
    push(K_DET, c + 1);
    low = 0; d = 0;
    forever begin
      c++;
      if (c >= N) return N;
      busy_exp[c] = 1'b1;
      if (intr(c)) begin do_abort(c); return c + 1; end
      d++;
      low = ss(c) ? 0 : low + 1;
      if (low == QL) break;
      if (d == MP) begin
        m_reject = m_reject + 8'd1;
        push(K_REJ, c + 1);
        return c + 1;
      end
    end
    q = c;
    for (int k = 1; k <= TA; k++) begin
      c = q + k;
      if (c >= N) return N;
      busy_exp[c] = 1'b1;
      if (intr(c)) begin do_abort(c); return c + 1; end
    end
    c = q + TA + 1;
    m_reply = m_reply + 8'd1;
    m_tx++;
    push(K_TX, c);
    n = 0;
    forever begin
      if (c >= N) return N;
      busy_exp[c] = 1'b1;
      if (intr(c)) begin do_abort(c); return c + 1; end
      n++;
      if (n >= HO && !txe[c]) return c + 1;
      c++;
    end
  endfunction

  // ---------------- monitor ----------------
  task automatic pop_cmp(input int kind);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d at cyc=%0d, want no event", kind, cyc);
      return;
    end
    e = exq.pop_front();
    if (e.kind != kind || e.at != cyc || e.rep !== reply_count || e.rej !== reject_count) begin
      failures++;
      $display("FAIL event: got kind=%0d cyc=%0d reply=%0d reject=%0d, want kind=%0d cyc=%0d reply=%0d reject=%0d",
               kind, cyc, reply_count, reject_count, e.kind, e.at, e.rep, e.rej);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      checks++;
      if (busy !== busy_exp[cyc]) begin
        failures++;
        if (busy_prints < 20) begin
          busy_prints++;
          $display("FAIL busy: cyc=%0d got=%b want=%b", cyc, busy, busy_exp[cyc]);
        end
      end
      if (cyc == wrap_start) tx_at_start = tx_seen;
      if (cyc == wrap_end) begin
        checks++;
        if (reply_count !== 8'd0) begin
          failures++;
          $display("FAIL wrap_reply: got=%0d want=0", reply_count);
        end
        checks++;
        if (tx_seen - tx_at_start != 256) begin
          failures++;
          $display("FAIL wrap_tx_pulses: got=%0d want=256", tx_seen - tx_at_start);
        end
      end
      if (det_stb === 1'b1) pop_cmp(K_DET);
      if (tx_stb === 1'b1) begin
        tx_seen++;
        pop_cmp(K_TX);
      end
      if (reject_count !== prev_rej) pop_cmp(K_REJ);
      prev_rej = reject_count;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0, kind, len, off;

    app(1'b0, 1'b1, 1'b0, 1'b1, 4);
    app(1'b0, 1'b1, 1'b0, 1'b0, 10);
    clean_ping();
    // weak burst
    for (int i = 0; i < 8; i++) app(bit'(i % 2 == 0), 1'b1, 1'b0, 1'b0, 1);
    app(1'b0, 1'b1, 1'b0, 1'b0, 20);
    // jam: abort exactly at MAX_PING
    app(1'b1, 1'b1, 1'b0, 1'b0, 108);
    app(1'b0, 1'b1, 1'b0, 1'b0, 30);
    // end-of-ping and MAX_PING on the same cycle
    app(1'b1, 1'b1, 1'b0, 1'b0, 104);
    app(1'b0, 1'b1, 1'b0, 1'b0, 50);
    // blanking: tx_en held across and beyond holdoff with sig pulses inside
    app(1'b1, 1'b1, 1'b0, 1'b0, 40);
    app(1'b0, 1'b1, 1'b0, 1'b0, 16);
    app(1'b0, 1'b1, 1'b1, 1'b0, 14);
    app(1'b1, 1'b1, 1'b1, 1'b0, 20);
    app(1'b0, 1'b1, 1'b1, 1'b0, 16);
    app(1'b0, 1'b1, 1'b0, 1'b0, 30);
    clean_ping();
    // sig while idle and tx_en high
    app(1'b0, 1'b1, 1'b1, 1'b0, 5);
    app(1'b1, 1'b1, 1'b1, 1'b0, 12);
    app(1'b0, 1'b1, 1'b1, 1'b0, 5);
    app(1'b0, 1'b1, 1'b0, 1'b0, 10);
    // enable drop during turnaround
    app(1'b1, 1'b1, 1'b0, 1'b0, 40);
    app(1'b0, 1'b1, 1'b0, 1'b0, 10);
    app(1'b0, 1'b0, 1'b0, 1'b0, 1);
    app(1'b0, 1'b1, 1'b0, 1'b0, 40);
    // reset during detect
    app(1'b1, 1'b1, 1'b0, 1'b0, 5);
    app(1'b1, 1'b1, 1'b0, 1'b1, 1);
    app(1'b0, 1'b1, 1'b0, 1'b0, 20);
    // counter wrap
    wrap_start = p;
    for (int i = 0; i < 256; i++) clean_ping();
    wrap_end = p;
    // random episodes
    while (p < N - 600) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: begin
          len = int'($urandom_range(10, 60));
          for (int i = 0; i < len; i++) app(bit'($urandom_range(0, 9) != 0), 1'b1, 1'b0, 1'b0, 1);
        end
        1: begin
          len = int'($urandom_range(8, 16));
          for (int i = 0; i < len; i++) app(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1);
        end
        2: app(1'b1, 1'b1, 1'b0, 1'b0, int'($urandom_range(100, 130)));
        3: begin
          off = int'($urandom_range(0, 80));
          for (int i = 0; i < 85; i++)
            app(bit'(i < 40), bit'(!(i >= off && i < off + 2)), 1'b0, 1'b0, 1);
        end
        default: begin
          p0 = int'($urandom_range(5, 30));
          for (int i = 0; i < p0; i++) app(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1);
        end
      endcase
      app(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 90)));
    end
    app(1'b0, 1'b1, 1'b0, 1'b0, N - p);

    begin
      int c;
      c = 0;
      while (c < N) c = episode(c);
    end

    cyc = 0;
    sig = sigd[0]; enable = en[0]; tx_en = txe[0]; rst = rs[0];
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      sig = sigd[c]; enable = en[c]; tx_en = txe[c]; rst = rs[c];
    end
    @(negedge clk);
    #1;

    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got=%0d left, want=0", exq.size());
    end
    checks++;
    if (tx_seen != m_tx) begin
      failures++;
      $display("FAIL tx_total: got=%0d want=%0d", tx_seen, m_tx);
    end
    checks++;
    if (reply_count !== m_reply) begin
      failures++;
      $display("FAIL final_reply: got=%0d want=%0d", reply_count, m_reply);
    end
    checks++;
    if (reject_count !== m_reject) begin
      failures++;
      $display("FAIL final_reject: got=%0d want=%0d", reject_count, m_reject);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ping_responder.md
Name: ping_responder

Overview:
- Far end of the RF ping link: listens on the digitized LVDS comparator stream, qualifies an incoming ping burst and waits for it to end.
- After a fixed turnaround delay it fires a one-cycle strobe into the tx burst generator.
- Sits between digitizer (sig) and tx (tx_stb/tx_en) in the transponder build. Counters feed hex_dump for UART reporting.

Parameters:
- DET_WIN, 64: qualification window length, in samples.
- DET_THR, 48: minimum high samples within the window to accept a ping.
- QUIET_LEN, 32: consecutive low samples that mark end of ping.
- MAX_PING, 48000: maximum cycles spent in QUIET before abort (jam/CW guard).
- TURNAROUND, 4800: cycles from end-of-ping to tx_stb (100 us at 48 MHz).
- HOLDOFF, 60000: minimum blanking cycles after tx_stb.
- CW, 16: width of the internal timers. All cycle parameters must be less than 2^CW.

Ports:
- clk, in, 1: system clock (48 MHz xtal).
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: responder armed. Low forces IDLE.
- sig, in, 1: digitized RF detector output.
- tx_en, in, 1: tx busy. Receiver is blanked while high.
- tx_stb, out, 1: one-cycle reply trigger to tx.
- det_stb, out, 1: one-cycle pulse when a ping is qualified.
- busy, out, 1: high in any state other than IDLE.
- reply_count, out, 8: replies sent. Wraps at 255→0.
- reject_count, out, 8: windows failing threshold plus MAX_PING aborts. Wraps.

Behaviour:
- **Input sync:** sig passes a 2-flop synchronizer, giving sig_s. All timing below is relative to sig_s.
- **Reset:** state=IDLE. tx_stb=0, det_stb=0, busy=0. Both counters=0. Timers and synchronizer flops=0.
- **enable=0:** next state is IDLE from any state, with no strobe and no counter change. It takes priority over everything except rst.
- **IDLE:**
  - If enable=1, tx_en=0 and sig_s=1 at cycle t: go to DETECT at t+1, with win_cnt=1 and high_cnt=1 (the sample at t counts).
  - If sig_s=1 while tx_en=1: ignored.
- **DETECT:**
  - Each cycle: win_cnt++, and high_cnt += sig_s.
  - On the cycle the DET_WIN-th sample is taken, decide:
    - high_cnt (including that sample) >= DET_THR: go to QUIET and pulse det_stb on the next cycle.
    - Otherwise: go to IDLE and increment reject_count.
  - Window occupies exactly DET_WIN cycles.
- **QUIET:**
  - low_run counts consecutive sig_s=0 samples; sig_s=1 clears it to 0. The counter starts at 0 on entry.
  - dur counts cycles in QUIET.
  - low_run reaching QUIET_LEN: go to TURN.
  - dur reaching MAX_PING first: go to IDLE and increment reject_count.
  - If both happen on the same cycle, QUIET_LEN wins.
- **TURN:**
  - Timer counts 1..TURNAROUND. On the cycle after the last count, tx_stb=1 for exactly one cycle, reply_count increments, and state goes to HOLD.
  - sig_s is ignored in TURN.
- **HOLD:**
  - Timer counts HOLDOFF cycles. Exit to IDLE only when the timer has expired and tx_en=0.
  - If tx_en stays high past HOLDOFF, remain in HOLD.
  - sig_s is ignored in HOLD.
- **Latency:**
  - From the QUIET_LEN-th low sig_s sample to tx_stb: exactly TURNAROUND+1 cycles.
  - From sig input to sig_s: 2 cycles.
- **Strobes:** tx_stb and det_stb are registered and never high for two consecutive cycles.
- **Counters:** 8-bit, plain modulo wrap (255+1=0).
- **Reset mid-operation:** any state returns to IDLE next edge. A pending tx_stb is never emitted.

Test Plan (DET_WIN=8, DET_THR=6, QUIET_LEN=4, MAX_PING=100, TURNAROUND=10, HOLDOFF=20):
- **Clean ping:** sig high 40 cycles, then low.
  - det_stb once. tx_stb exactly 11 cycles after the 4th low sig_s sample. reply_count=1. busy returns low 20 cycles after tx_stb, with tx_en held 0.
- **Weak burst:** sig pattern 1,0,1,0,1,0,1,0.
  - No det_stb. reject_count=1. IDLE after 8 cycles. No tx_stb.
- **Jam:** sig held high 200 cycles after qualification.
  - det_stb once. Abort at dur=100. reject_count=1. No tx_stb.
- **Blanking:** after tx_stb, hold tx_en=1 for 50 cycles and pulse sig during it.
  - HOLD persists until tx_en falls (beyond 20 cycles). No new DETECT. The next ping after that is answered (reply_count=2).
- **Abort:** drop enable during TURN. Separately, assert rst during DETECT.
  - IDLE next cycle, no tx_stb, counters unchanged (rst: counters=0).
- **Wrap:** 256 clean pings.
  - reply_count reads 0, and 256 tx_stb pulses are observed.
